// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns a raw PLL lock flag into a clean design-wide reset in the PLL clock domain
module pll_reset_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int HOLD_CYCLES   = 8,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pll_locked,
   output logic             sys_reset,
   output logic             ready,
   output logic             lock_lost_pulse,
   output logic [CNT_W-1:0] lock_loss_count
);
   localparam int MAXC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int TW = $clog2(MAXC + 1);
   localparam logic [TW-1:0] T_ONE = TW'(1);
   localparam logic [TW-1:0] S_LAST = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] H_LAST = TW'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD, RUN} state_t;

   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [TW-1:0] timer_q, timer_d;
   logic sys_reset_q, sys_reset_d;
   logic ready_q, ready_d;
   logic pulse_q, pulse_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic locked_s;

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Synchronizer for the asynchronous lock flag
   always_ff @(posedge clk)
      if (reset) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};

   // Next state: the current locked_s sample counts toward the stable window, so STABILIZE exits one timer step early
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pulse_d = 1'b0;
      count_d = count_q;
      case (state_q)
         WAIT_LOCK:
            if (locked_s) begin
               state_d = (STABLE_CYCLES == 1) ? HOLD : STABILIZE;
               timer_d = T_ONE;
            end
         STABILIZE:
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == S_LAST) begin
               state_d = HOLD;
               timer_d = T_ONE;
            end else timer_d = timer_q + T_ONE;
         HOLD:
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == H_LAST) begin
               state_d = RUN;
               timer_d = '0;
            end else timer_d = timer_q + T_ONE;
         RUN:
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
               pulse_d = 1'b1;
               count_d = (&count_q) ? count_q : count_q + C_ONE;
            end
      endcase
      sys_reset_d = state_d != RUN;
      ready_d = state_d == RUN;
   end

   // FSM and registered outputs
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= WAIT_LOCK;
         timer_q <= '0;
         sys_reset_q <= 1'b1;
         ready_q <= 1'b0;
         pulse_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sys_reset_q <= sys_reset_d;
         ready_q <= ready_d;
         pulse_q <= pulse_d;
         count_q <= count_d;
      end

   assign sys_reset = sys_reset_q;
   assign ready = ready_q;
   assign lock_lost_pulse = pulse_q;
   assign lock_loss_count = count_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: vector table, directed latency/loss sequences and random lock traffic against a run-length model
module tb_pll_reset_sequencer;
   localparam int SS = 2;
   localparam int SC = 16;
   localparam int HC = 8;
   localparam int RUN_LEN = SC + HC;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pll_locked = 1'b0;
   logic sr8, rdy8, pl8;
   logic [7:0] cnt8;
   logic sr2, rdy2, pl2;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   // model: synchronizer history plus length of the current unbroken run of locked samples
   logic sh [SS];
   int run_len = 0;
   int m_cnt8 = 0;
   int m_cnt2 = 0;
   logic m_pulse = 1'b0;
   int pulses_seen = 0;

   pll_reset_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .pll_locked(pll_locked), .sys_reset(sr8), .ready(rdy8),
      .lock_lost_pulse(pl8), .lock_loss_count(cnt8));

   pll_reset_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .pll_locked(pll_locked), .sys_reset(sr2), .ready(rdy2),
      .lock_lost_pulse(pl2), .lock_loss_count(cnt2));

   always #5 clk = ~clk;

   typedef struct {
      logic r;
      logic p;
      logic sr;
      logic rdy;
      logic pls;
      int   cnt;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic p);
      logic ls;
      if (r) begin
         for (int i = 0; i < SS; i++) sh[i] = 1'b0;
         run_len = 0;
         m_cnt8 = 0;
         m_cnt2 = 0;
         m_pulse = 1'b0;
      end else begin
         ls = sh[SS-1];
         for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
         sh[0] = p;
         m_pulse = 1'b0;
         if (ls) run_len = (run_len < RUN_LEN) ? run_len + 1 : RUN_LEN;
         else begin
            if (run_len >= RUN_LEN) begin
               m_pulse = 1'b1;
               m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
               m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            run_len = 0;
         end
      end
   endtask

   task automatic tick(input logic r, input logic p);
      logic up;
      reset = r;
      pll_locked = p;
      @(posedge clk);
      model_step(r, p);
      #1;
      up = run_len >= RUN_LEN;
      chk("sys_reset8", int'(sr8), int'(!up));
      chk("ready8", int'(rdy8), int'(up));
      chk("pulse8", int'(pl8), int'(m_pulse));
      chk("count8", int'(cnt8), m_cnt8);
      chk("sys_reset2", int'(sr2), int'(!up));
      chk("ready2", int'(rdy2), int'(up));
      chk("pulse2", int'(pl2), int'(m_pulse));
      chk("count2", int'(cnt2), m_cnt2);
      if (pl8) pulses_seen++;
   endtask

   task automatic wait_ready(output int n);
      n = -1;
      for (int i = 0; i < 80; i++) begin
         tick(1'b0, 1'b1);
         if (rdy8) begin
            n = i;
            break;
         end
      end
   endtask

   vec_t tbl [10];
   int n, base;

   initial begin
      for (int i = 0; i < SS; i++) sh[i] = 1'b0;
      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      for (int i = 0; i < 10; i++) begin
         tick(tbl[i].r, tbl[i].p);
         chk("tbl_sys_reset", int'(sr8), int'(tbl[i].sr));
         chk("tbl_ready", int'(rdy8), int'(tbl[i].rdy));
         chk("tbl_pulse", int'(pl8), int'(tbl[i].pls));
         chk("tbl_count", int'(cnt8), tbl[i].cnt);
      end
      // lock held from edge 0: table covered edges 0..5, ready must first appear after edge 25
      wait_ready(n);
      chk("lock_latency_edge", n + 6, 25);
      chk("no_pulse_on_lock", pulses_seen, 0);
      // one-cycle loss in RUN
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("loss_not_yet", int'(sr8), 0);
      tick(1'b0, 1'b1);
      chk("loss_sys_reset", int'(sr8), 1);
      chk("loss_pulse", int'(pl8), 1);
      chk("loss_count", int'(cnt8), 1);
      tick(1'b0, 1'b1);
      chk("pulse_one_cycle", int'(pl8), 0);
      wait_ready(n);
      chk("relock_latency", n + 4, 26);
      // glitches during STABILIZE and HOLD restart the sequence without counting
      tick(1'b1, 1'b0);
      base = pulses_seen;
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
      chk("glitch1_held", int'(sr8), 1);
      tick(1'b0, 1'b0);
      wait_ready(n);
      chk("glitch_relock_latency", n + 1, 26);
      chk("glitch_no_pulse", pulses_seen - base, 0);
      chk("glitch_count", int'(cnt8), 0);
      // five losses from RUN: narrow counter saturates at 3
      base = pulses_seen;
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, 1'b0);
         tick(1'b0, 1'b1);
         tick(1'b0, 1'b1);
         chk("sat_count2", int'(cnt2), (k < 3) ? k + 1 : 3);
         chk("sat_count8", int'(cnt8), k + 1);
         wait_ready(n);
         chk("sat_relock", n + 3, 26);
      end
      chk("sat_pulses", pulses_seen - base, 5);
      // reset mid-RUN, then mid-HOLD
      tick(1'b1, 1'b1);
      chk("rst_run_sys_reset", int'(sr8), 1);
      chk("rst_run_count", int'(cnt8), 0);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("rst_hold_sys_reset", int'(sr8), 1);
      wait_ready(n);
      chk("rst_hold_relock", n + 1, 26);
      // random lock traffic with occasional resets
      for (int seg = 0; seg < 120; seg++) begin
         int hi, lo;
         hi = $urandom_range(1, 40);
         lo = $urandom_range(1, 3);
         for (int i = 0; i < hi; i++) tick($urandom_range(0, 199) == 0, 1'b1);
         for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
      end
      // stuck low
      for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
      chk("stuck_low_sys_reset", int'(sr8), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
